// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter / return-stack unit.
// Relative branching is compiled in only when PC_REL_BRANCH_EN is defined.
package pc_pkg;

    localparam int DEF_WORD_SIZE   = 8;
    localparam int DEF_STACK_DEPTH = 4;

    typedef enum logic [2:0] {
        OP_NONE = 3'd0,
        OP_LOAD = 3'd1,
        OP_CALL = 3'd2,
        OP_RET  = 3'd3,
        OP_BR   = 3'd4,
        OP_INC  = 3'd5
    } op_e;

    // Fixed priority: load > call > ret > branch > increment.
    function automatic op_e decode_op(input logic ld, input logic call,
                                      input logic ret, input logic br,
                                      input logic inc);
        op_e op;
        if (ld)        op = OP_LOAD;
        else if (call) op = OP_CALL;
        else if (ret)  op = OP_RET;
        else if (br)   op = OP_BR;
        else if (inc)  op = OP_INC;
        else           op = OP_NONE;
        return op;
    endfunction

endpackage

// File: rtl/ret_addr_stack.sv
// LIFO of return addresses; depth alone defines which entries are valid.
// Push is ignored when full, pop is ignored when empty or when pushing.
module ret_addr_stack
    import pc_pkg::*;
#(
    parameter int WORD_SIZE   = DEF_WORD_SIZE,
    parameter int STACK_DEPTH = DEF_STACK_DEPTH
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               push,
    input  logic                               pop,
    input  logic [WORD_SIZE-1:0]               push_data,
    output logic [WORD_SIZE-1:0]               top,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   depth,
    output logic                               full,
    output logic                               empty
);

    localparam int DW = $clog2(STACK_DEPTH + 1);
    localparam int AW = $clog2(STACK_DEPTH);

    logic [WORD_SIZE-1:0] r_mem [STACK_DEPTH];
    logic [DW-1:0]        r_depth;
    logic                 w_push_ok;
    logic                 w_pop_ok;
    logic [AW-1:0]        w_wr_idx;
    logic [AW-1:0]        w_top_idx;

    assign full      = (r_depth == DW'(STACK_DEPTH));
    assign empty     = (r_depth == DW'(0));
    assign depth     = r_depth;
    assign w_push_ok = push & ~full;
    assign w_pop_ok  = pop & ~push & ~empty;
    assign w_wr_idx  = AW'(r_depth);
    assign w_top_idx = AW'(r_depth - DW'(1));
    assign top       = empty ? WORD_SIZE'(0) : r_mem[w_top_idx];

    // Entry storage: no reset, contents are meaningless beyond depth.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[w_wr_idx] <= push_data;
        end
    end

    // Occupancy counter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_depth <= DW'(0);
        end else if (w_push_ok) begin
            r_depth <= r_depth + DW'(1);
        end else if (w_pop_ok) begin
            r_depth <= r_depth - DW'(1);
        end else begin
            r_depth <= r_depth;
        end
    end

endmodule

// File: rtl/pc_stack_unit.sv
// Program counter with load, call/return stack, increment and optional
// relative branch (enabled by defining PC_REL_BRANCH_EN).
module pc_stack_unit
    import pc_pkg::*;
#(
    parameter int WORD_SIZE   = DEF_WORD_SIZE,
    parameter int STACK_DEPTH = DEF_STACK_DEPTH
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [WORD_SIZE-1:0]               data_in,
    input  logic [WORD_SIZE-1:0]               offset,
    input  logic                               Load_PC,
    input  logic                               Inc_PC,
    input  logic                               Call_PC,
    input  logic                               Ret_PC,
    input  logic                               Br_PC,
    input  logic                               clr_err,
    output logic [WORD_SIZE-1:0]               count,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   depth,
    output logic                               stack_full,
    output logic                               stack_empty,
    output logic                               ovf_err,
    output logic                               unf_err
);

    logic [WORD_SIZE-1:0] r_count;
    logic                 r_ovf;
    logic                 r_unf;
    logic [WORD_SIZE-1:0] w_next_count;
    logic [WORD_SIZE-1:0] w_top;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_set_ovf;
    logic                 w_set_unf;
    logic                 w_br_req;
    op_e                  w_op;

`ifdef PC_REL_BRANCH_EN
    assign w_br_req = Br_PC;
`else
    // Branch request and offset are deliberately left unconnected.
    logic w_unused_br;
    assign w_unused_br = ^{offset, Br_PC};
    assign w_br_req    = 1'b0;
`endif

    assign w_op = decode_op(Load_PC, Call_PC, Ret_PC, w_br_req, Inc_PC);

    // Next-state selection for the PC and stack/error side effects.
    always_comb begin
        w_next_count = r_count;
        w_push       = 1'b0;
        w_pop        = 1'b0;
        w_set_ovf    = 1'b0;
        w_set_unf    = 1'b0;
        case (w_op)
            OP_LOAD: w_next_count = data_in;
            OP_CALL: begin
                if (!stack_full) begin
                    w_push       = 1'b1;
                    w_next_count = data_in;
                end else begin
                    w_set_ovf    = 1'b1;
                end
            end
            OP_RET: begin
                if (!stack_empty) begin
                    w_pop        = 1'b1;
                    w_next_count = w_top;
                end else begin
                    w_set_unf    = 1'b1;
                end
            end
`ifdef PC_REL_BRANCH_EN
            OP_BR:   w_next_count = r_count + offset;
`endif
            OP_INC:  w_next_count = r_count + WORD_SIZE'(1);
            default: w_next_count = r_count;
        endcase
    end

    ret_addr_stack #(
        .WORD_SIZE   (WORD_SIZE),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .pop       (w_pop),
        .push_data (r_count + WORD_SIZE'(1)),
        .top       (w_top),
        .depth     (depth),
        .full      (stack_full),
        .empty     (stack_empty)
    );

    // PC register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_count <= WORD_SIZE'(0);
        end else begin
            r_count <= w_next_count;
        end
    end

    // Sticky error flags; a new error wins over a simultaneous clear.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            r_ovf <= w_set_ovf | (r_ovf & ~clr_err);
            r_unf <= w_set_unf | (r_unf & ~clr_err);
        end
    end

    assign count   = r_count;
    assign ovf_err = r_ovf;
    assign unf_err = r_unf;

endmodule
